ascii_expr_parser: RTL and testbench
====================================

# ascii_expr_parser

- Upstream front end of the warm-up calculator datapath.
- Consumes a byte stream of ASCII characters (from the serial receiver) forming expressions such as `-12*7=`.
- Parses each expression into two signed 8-bit operands plus an ASCII operator code, then presents them to the ALU stage (`data_a`, `data_b`, `operation`) with a one-cycle command strobe.
- Malformed or out-of-range input is reported and discarded without disturbing the last valid command.

## Interface

Parameters:
- MAX_DIGITS, 3, maximum decimal digits per operand; more is a parse error.

Ports:
- clock  in  1  system clock, 50 MHz; all logic on rising edge.
- reset  in  1  synchronous, active-low; sampled on the rising edge of `clock`.
- rx_data  in  8  ASCII character from the receiver.
- rx_valid  in  1  `rx_data` valid this cycle; every valid cycle is consumed (no backpressure).
- data_a  out  8  signed operand A, two's complement.
- data_b  out  8  signed operand B, two's complement.
- operation  out  8  ASCII operator: 0x2B `+`, 0x2D `-`, 0x2A `*`, 0x2F `/`, 0x26 `&`, 0x7C `|`.
- cmd_valid  out  1  one-cycle pulse; `data_a`/`data_b`/`operation` updated this cycle.
- parse_error  out  1  one-cycle pulse on detection of a syntax or range error.

## Operation

Character classes:
- digit: 0x30-0x39
- minus: 0x2D
- op: the six operator codes above
- space: 0x20
- term: `=` (0x3D) or CR (0x0D)

Internal state:
- sign flag per operand
- 8-bit magnitude accumulator, updated as acc*10 + digit
- digit counter

Rules:
- Spaces are ignored in every state.
- Any character not listed for a state is an error.

States (reset state A_SIGN):
- A_SIGN
  - minus, with sign clear: set neg_a, stay.
  - digit: acc=digit, cnt=1, go to A_DIG.
- A_DIG
  - digit: if cnt==MAX_DIGITS, error; else acc=acc*10+d, cnt++.
  - op: range-check A, latch A and op, clear acc/cnt, go to B_SIGN.
- B_SIGN
  - Same as A_SIGN, for B. A minus here is always B's sign.
- B_DIG
  - digit: same as A_DIG.
  - term: range-check B, then:
    - update `data_a`, `data_b`, `operation` with the latched values;
    - pulse `cmd_valid`;
    - clear signs/acc/cnt;
    - go to A_SIGN.
- FLUSH
  - Discard characters until a term, then go to A_SIGN.

Range check:
- Positive magnitude ≤ 127; negative magnitude ≤ 128.
- Output value is the two's complement of the magnitude when the sign is set.
- Use a ≥10-bit accumulator so 999 is representable before the check.

Error handling:
- `parse_error` pulses in the cycle after the offending character.
- Signs, acc and cnt are cleared.
- If the offending character is itself a term, go directly to A_SIGN; otherwise go to FLUSH.

Output behaviour:
- `data_a`, `data_b` and `operation` hold their value between commands; errors never modify them.
- Only one of `cmd_valid` and `parse_error` can pulse per cycle.

## Timing

Reset values (reset low at a rising edge):
- `data_a` = 0, `data_b` = 0, `operation` = 0x00
- `cmd_valid` = 0, `parse_error` = 0
- state A_SIGN, all internal registers cleared

Reset behaviour:
- Reset mid-expression abandons the expression; no pulse is generated.
- `rx_valid` is ignored while reset is low.

Latency:
- Character accepted at edge N → `cmd_valid` / `parse_error` high during cycle N+1, for exactly one cycle.
- New output values are visible in the same cycle as `cmd_valid`.

Throughput:
- One character per cycle; back-to-back `rx_valid` is supported.
- `rx_valid` low cycles between characters have no effect, at any length.
- A new expression may begin on the cycle immediately after its predecessor's terminator.

Downstream:
- The ALU registers its inputs; operands remain stable until the next `cmd_valid`, so no handshake is required.

## Test plan

- **Basic command:** `12+5=` back-to-back.
  - `cmd_valid` one cycle after `=`.
  - `data_a`=0x0C, `data_b`=0x05, `operation`=0x2B.
- **Signs and spaces:** `-128 * -1=` with random `rx_valid` gaps.
  - `data_a`=0x80, `data_b`=0xFF, `operation`=0x2A.
  - Exactly one `cmd_valid`.
- **Range error and recovery:** `128+1=` then `3&6=`.
  - `parse_error` one cycle after `+`.
  - No `cmd_valid` for the first expression.
  - Outputs unchanged until `3&6=` gives `data_a`=0x03, `data_b`=0x06, `operation`=0x26.
- **Syntax errors:**
  - `1234+1=`: error on the 4th digit.
  - `5+=`: error on `=`, returns to A_SIGN directly.
  - `--3+1=`: error on the 2nd minus.
  - Each case produces a single `parse_error` and no `cmd_valid`; a following `-7/2=` yields 0xF9, 0x02, 0x2F.
- **Reset mid-expression:** `7|`, reset low for 1 cycle, then `2-3=`.
  - No pulse during reset; all outputs 0 after reset.
  - Then `data_a`=0x02, `data_b`=0x03, `operation`=0x2D.
- **Minus as operator vs sign:** `-5--5` followed by CR.
  - `data_a`=0xFB, `operation`=0x2D, `data_b`=0xFB.

Source files
------------

// File: rtl/ascii_expr_parser.sv
// ASCII expression front end: turns "<a><op><b>=" character streams into
// signed 8-bit operands plus an operator code for the ALU stage.
module ascii_expr_parser #(
    parameter int MAX_DIGITS = 3
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_valid,
    output logic [7:0] data_a,
    output logic [7:0] data_b,
    output logic [7:0] operation,
    output logic       cmd_valid,
    output logic       parse_error
);
    // Accumulator wide enough for MAX_DIGITS nines before the range check.
    localparam int AW = 4 * MAX_DIGITS;
    localparam int CW = $clog2(MAX_DIGITS + 1);

    typedef enum logic [2:0] {A_SIGN, A_DIG, B_SIGN, B_DIG, FLUSH} state_t;

    state_t          r_state, w_state_nxt;
    logic            r_neg_a, r_neg_b;
    logic [AW-1:0]   r_acc;
    logic [CW-1:0]   r_cnt;
    logic [7:0]      r_a_val, r_op;

    logic w_is_dig, w_is_minus, w_is_op, w_is_sp, w_is_term;
    logic w_cur_neg, w_in_range;
    logic [7:0]    w_val;
    logic [AW-1:0] w_digit, w_acc_mac;
    logic w_err, w_cmd, w_neg_set, w_acc_start, w_acc_step, w_latch_a;

    assign w_is_dig   = (rx_data >= 8'h30) && (rx_data <= 8'h39);
    assign w_is_minus = (rx_data == 8'h2D);
    assign w_is_op    = (rx_data == 8'h2B) || (rx_data == 8'h2D) || (rx_data == 8'h2A) ||
                        (rx_data == 8'h2F) || (rx_data == 8'h26) || (rx_data == 8'h7C);
    assign w_is_sp    = (rx_data == 8'h20);
    assign w_is_term  = (rx_data == 8'h3D) || (rx_data == 8'h0D);

    // Sign of whichever operand is currently being assembled.
    assign w_cur_neg  = (r_state == A_SIGN || r_state == A_DIG) ? r_neg_a : r_neg_b;
    // Negative side reaches one further (-128).
    assign w_in_range = w_cur_neg ? (r_acc <= AW'(128)) : (r_acc <= AW'(127));
    assign w_val      = w_cur_neg ? 8'(~r_acc[7:0] + 8'd1) : r_acc[7:0];
    assign w_digit    = AW'(rx_data[3:0]);
    assign w_acc_mac  = AW'(r_acc * AW'(10)) + w_digit;

    // Action decode: what the current character does in the current state.
    always_comb begin
        w_err       = 1'b0;
        w_cmd       = 1'b0;
        w_neg_set   = 1'b0;
        w_acc_start = 1'b0;
        w_acc_step  = 1'b0;
        w_latch_a   = 1'b0;
        if (rx_valid && !w_is_sp) begin
            case (r_state)
                A_SIGN, B_SIGN: begin
                    if (w_is_minus && !w_cur_neg) w_neg_set   = 1'b1;
                    else if (w_is_dig)            w_acc_start = 1'b1;
                    else                          w_err       = 1'b1;
                end
                A_DIG: begin
                    if (w_is_dig) begin
                        if (r_cnt == CW'(MAX_DIGITS)) w_err = 1'b1;
                        else                          w_acc_step = 1'b1;
                    end else if (w_is_op) begin
                        if (w_in_range) w_latch_a = 1'b1;
                        else            w_err     = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                B_DIG: begin
                    if (w_is_dig) begin
                        if (r_cnt == CW'(MAX_DIGITS)) w_err = 1'b1;
                        else                          w_acc_step = 1'b1;
                    end else if (w_is_term) begin
                        if (w_in_range) w_cmd = 1'b1;
                        else            w_err = 1'b1;
                    end else begin
                        w_err = 1'b1;
                    end
                end
                default: ;  // FLUSH swallows everything silently
            endcase
        end
    end

    // Next-state selection; an error on a terminator resyncs immediately.
    always_comb begin
        w_state_nxt = r_state;
        if (w_err) begin
            w_state_nxt = w_is_term ? A_SIGN : FLUSH;
        end else begin
            case (r_state)
                A_SIGN:  if (w_acc_start) w_state_nxt = A_DIG;
                A_DIG:   if (w_latch_a)   w_state_nxt = B_SIGN;
                B_SIGN:  if (w_acc_start) w_state_nxt = B_DIG;
                B_DIG:   if (w_cmd)       w_state_nxt = A_SIGN;
                default: if (rx_valid && w_is_term) w_state_nxt = A_SIGN;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) r_state <= A_SIGN;
        else        r_state <= w_state_nxt;
    end

    // Operand assembly, command latching and the one-cycle pulses.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_neg_a     <= 1'b0;
            r_neg_b     <= 1'b0;
            r_acc       <= '0;
            r_cnt       <= '0;
            r_a_val     <= 8'h00;
            r_op        <= 8'h00;
            data_a      <= 8'h00;
            data_b      <= 8'h00;
            operation   <= 8'h00;
            cmd_valid   <= 1'b0;
            parse_error <= 1'b0;
        end else begin
            cmd_valid   <= w_cmd;
            parse_error <= w_err;
            if (w_err || w_cmd) begin
                r_neg_a <= 1'b0;
                r_neg_b <= 1'b0;
                r_acc   <= '0;
                r_cnt   <= '0;
            end else begin
                if (w_neg_set) begin
                    if (r_state == A_SIGN) r_neg_a <= 1'b1;
                    else                   r_neg_b <= 1'b1;
                end
                if (w_acc_start) begin
                    r_acc <= w_digit;
                    r_cnt <= CW'(1);
                end
                if (w_acc_step) begin
                    r_acc <= w_acc_mac;
                    r_cnt <= r_cnt + CW'(1);
                end
                if (w_latch_a) begin
                    r_a_val <= w_val;
                    r_op    <= rx_data;
                    r_acc   <= '0;
                    r_cnt   <= '0;
                end
            end
            if (w_cmd) begin
                data_a    <= r_a_val;
                data_b    <= w_val;
                operation <= r_op;
            end
        end
    end
endmodule

// File: tb/tb_ascii_expr_parser.sv
// Scoreboard bench for ascii_expr_parser: every expected pulse is queued
// when its triggering character is driven and checked when the DUT pulses.
module tb_ascii_expr_parser;
    logic       clock = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] rx_data = 8'h00;
    logic       rx_valid = 1'b0;
    logic [7:0] data_a, data_b, operation;
    logic       cmd_valid, parse_error;

    ascii_expr_parser #(.MAX_DIGITS(3)) dut (
        .clock(clock), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
        .data_a(data_a), .data_b(data_b), .operation(operation),
        .cmd_valid(cmd_valid), .parse_error(parse_error)
    );

    always #10 clock = ~clock;

    typedef struct {
        int         cyc;
        bit         err;
        logic [7:0] a, b, op;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   total = 0;
    int   bad = 0;
    logic [7:0] m_a = 8'h00, m_b = 8'h00, m_op = 8'h00;

    always @(posedge clock) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h (cyc %0d)", tag, got, exp, cyc);
        end
    endtask

    // Pulse monitor: sampled mid-cycle, away from the active edge.
    exp_t e;
    always @(negedge clock) begin
        if (cmd_valid || parse_error) begin
            chk("excl", {31'd0, cmd_valid & parse_error}, 32'd0);
            if (q.size() == 0) begin
                chk("unexp_pulse", {30'd0, cmd_valid, parse_error}, 32'd0);
            end else begin
                e = q.pop_front();
                chk("pulse_cyc", cyc, e.cyc);
                chk("pulse_kind", {30'd0, cmd_valid, parse_error}, e.err ? 32'd1 : 32'd2);
                chk("data_a", {24'd0, data_a}, {24'd0, e.a});
                chk("data_b", {24'd0, data_b}, {24'd0, e.b});
                chk("operation", {24'd0, operation}, {24'd0, e.op});
            end
        end
    end

    task automatic send_ch(input byte c, input bit trig, input bit err, input bit gaps);
        exp_t x;
        rx_data  = c;
        rx_valid = 1'b1;
        if (trig) begin
            x.cyc = cyc + 1; x.err = err; x.a = m_a; x.b = m_b; x.op = m_op;
            q.push_back(x);
        end
        @(posedge clock); #1;
        rx_valid = 1'b0;
        rx_data  = 8'($urandom);
        if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clock); #1; end
    endtask

    // err=0: command on the final character with outputs ea/eb/eop.
    // err=1: error pulse on character index trig, outputs must be unchanged.
    task automatic run(input string s, input int trig, input bit err,
                       input logic [7:0] ea, input logic [7:0] eb, input logic [7:0] eop,
                       input bit gaps);
        int t;
        t = err ? trig : s.len() - 1;
        for (int i = 0; i < s.len(); i++) begin
            if (i == t && !err) begin m_a = ea; m_b = eb; m_op = eop; end
            send_ch(s[i], i == t, err, gaps);
        end
    endtask

    task automatic chk_outs_zero(input string tag);
        chk({tag, "_a"}, {24'd0, data_a}, 32'd0);
        chk({tag, "_b"}, {24'd0, data_b}, 32'd0);
        chk({tag, "_op"}, {24'd0, operation}, 32'd0);
        chk({tag, "_cmd"}, {31'd0, cmd_valid}, 32'd0);
        chk({tag, "_err"}, {31'd0, parse_error}, 32'd0);
    endtask

    initial begin
        repeat (2) @(posedge clock);
        #1 reset = 1'b1;
        @(negedge clock);
        chk_outs_zero("rst");
        @(posedge clock); #1;

        run("12+5=", 0, 0, 8'h0C, 8'h05, 8'h2B, 0);
        run("-128 * -1=", 0, 0, 8'h80, 8'hFF, 8'h2A, 1);
        run("128+1=", 3, 1, 0, 0, 0, 0);
        run("3&6=", 0, 0, 8'h03, 8'h06, 8'h26, 0);
        run("1234+1=", 3, 1, 0, 0, 0, 0);
        run("-7/2=", 0, 0, 8'hF9, 8'h02, 8'h2F, 0);
        run("5+=", 2, 1, 0, 0, 0, 0);
        run("-7/2=", 0, 0, 8'hF9, 8'h02, 8'h2F, 1);
        run("--3+1=", 1, 1, 0, 0, 0, 0);
        run("-7/2=", 0, 0, 8'hF9, 8'h02, 8'h2F, 0);
        run("127+-128=", 0, 0, 8'h7F, 8'h80, 8'h2B, 0);
        run("-129+0=", 4, 1, 0, 0, 0, 0);
        run("999|1=", 3, 1, 0, 0, 0, 1);
        run("4|-999=", 6, 1, 0, 0, 0, 0);

        // Reset mid-expression; characters offered during reset are ignored.
        run("7|", 99, 1, 0, 0, 0, 0);
        reset = 1'b0; rx_valid = 1'b1; rx_data = 8'h3D;
        @(posedge clock); #1;
        reset = 1'b1; rx_valid = 1'b0;
        m_a = 8'h00; m_b = 8'h00; m_op = 8'h00;
        @(negedge clock);
        chk_outs_zero("midrst");
        @(posedge clock); #1;
        run("2-3=", 0, 0, 8'h02, 8'h03, 8'h2D, 0);
        run("-5--5\015", 0, 0, 8'hFB, 8'hFB, 8'h2D, 0);

        repeat (5) @(posedge clock);
        chk("q_empty", q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
